// File: rtl/vga_timing.sv
// VGA raster timing generator (1024x768 @ 60 Hz, 65 MHz pixel clock): registered counters, syncs, blanks.
// Optional frame counter enabled by defining VGA_TIMING_FRAME_CNT_EN; otherwise frame_cnt is tied to 0.
module vga_timing #(
  parameter int H_TOTAL     = 1344,
  parameter int H_ACTIVE    = 1024,
  parameter int HSYNC_START = 1048,
  parameter int HSYNC_STOP  = 1184,
  parameter int V_TOTAL     = 806,
  parameter int V_ACTIVE    = 768,
  parameter int VSYNC_START = 771,
  parameter int VSYNC_STOP  = 777,
  parameter int CNT_W       = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             hsync,
  output logic             vsync,
  output logic             hblnk,
  output logic             vblnk,
  output logic             frame_start,
  output logic [15:0]      frame_cnt
);

  // Comparisons run one bit wider so a sync/total bound equal to 2**CNT_W does not alias to 0.
  typedef logic [CNT_W:0] cmp_t;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam cmp_t             H_ACT_C  = cmp_t'(H_ACTIVE);
  localparam cmp_t             HS_STA_C = cmp_t'(HSYNC_START);
  localparam cmp_t             HS_STO_C = cmp_t'(HSYNC_STOP);
  localparam cmp_t             V_ACT_C  = cmp_t'(V_ACTIVE);
  localparam cmp_t             VS_STA_C = cmp_t'(VSYNC_START);
  localparam cmp_t             VS_STO_C = cmp_t'(VSYNC_STOP);

  if (!(H_ACTIVE < HSYNC_START && HSYNC_START < HSYNC_STOP && HSYNC_STOP <= H_TOTAL)) begin : g_bad_h
    $fatal(1, "vga_timing: horizontal parameters out of order");
  end
  if (!(V_ACTIVE < VSYNC_START && VSYNC_START < VSYNC_STOP && VSYNC_STOP <= V_TOTAL)) begin : g_bad_v
    $fatal(1, "vga_timing: vertical parameters out of order");
  end
  if ((64'd1 << CNT_W) < 64'(H_TOTAL) || (64'd1 << CNT_W) < 64'(V_TOTAL)) begin : g_bad_w
    $fatal(1, "vga_timing: CNT_W too narrow for H_TOTAL/V_TOTAL");
  end

  logic [CNT_W-1:0] h_next;
  logic [CNT_W-1:0] v_next;
  logic             h_last;
  logic             v_last;
  logic             wrap;
  cmp_t             h_cmp;
  cmp_t             v_cmp;

  // Flags are derived from the next counter values so they land in the same register stage.
  always_comb begin
    h_last = (hcount == H_LAST);
    v_last = (vcount == V_LAST);
    wrap   = h_last && v_last;
    h_next = h_last ? '0 : hcount + 1'b1;
    v_next = vcount;
    if (h_last) begin
      v_next = v_last ? '0 : vcount + 1'b1;
    end
    h_cmp = cmp_t'(h_next);
    v_cmp = cmp_t'(v_next);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount      <= '0;
      vcount      <= '0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      hblnk       <= 1'b0;
      vblnk       <= 1'b0;
      frame_start <= 1'b0;
    end else if (en) begin
      hcount      <= h_next;
      vcount      <= v_next;
      hblnk       <= (h_cmp >= H_ACT_C);
      hsync       <= (h_cmp >= HS_STA_C) && (h_cmp < HS_STO_C);
      vblnk       <= (v_cmp >= V_ACT_C);
      vsync       <= (v_cmp >= VS_STA_C) && (v_cmp < VS_STO_C);
      frame_start <= wrap;
    end else begin
      frame_start <= 1'b0;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  // Advances on the same edge that raises frame_start; wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
    end else if (en && wrap) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// Self-checking bench for vga_timing: full-size instance plus a shrunken-raster instance for frame-level checks.
// Reference model derives every output from the count of enabled cycles since reset.
module tb_vga_timing;

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    logic        fs;
    logic [15:0] fc;
  } bus_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;

  logic [10:0] hcount_b, vcount_b;
  logic        hsync_b, vsync_b, hblnk_b, vblnk_b, fs_b;
  logic [15:0] fc_b;
  logic [4:0]  hcount_s, vcount_s;
  logic        hsync_s, vsync_s, hblnk_s, vblnk_s, fs_s;
  logic [15:0] fc_s;

  int          checks = 0;
  int          errors = 0;
  longint      ticks = 0;
  bit          adv = 1'b0;
  longint      fc_base_s = 0;

  always #5 clk = ~clk;

  vga_timing dut_b (
    .clk(clk), .rst_n(rst_n), .en(en),
    .hcount(hcount_b), .vcount(vcount_b),
    .hsync(hsync_b), .vsync(vsync_b), .hblnk(hblnk_b), .vblnk(vblnk_b),
    .frame_start(fs_b), .frame_cnt(fc_b)
  );

  vga_timing #(
    .H_TOTAL(20), .H_ACTIVE(12), .HSYNC_START(14), .HSYNC_STOP(17),
    .V_TOTAL(15), .V_ACTIVE(10), .VSYNC_START(11), .VSYNC_STOP(13),
    .CNT_W(5)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .en(en),
    .hcount(hcount_s), .vcount(vcount_s),
    .hsync(hsync_s), .vsync(vsync_s), .hblnk(hblnk_s), .vblnk(vblnk_s),
    .frame_start(fs_s), .frame_cnt(fc_s)
  );

  // Position is simply (enabled cycles) folded into a raster of HT x VT.
  function automatic bus_t model(input longint t, input bit a,
                                 input int ht, input int ha, input int hss, input int hsp,
                                 input int vt, input int va, input int vss, input int vsp,
                                 input longint base);
    bus_t   b;
    longint h, v, f;
    h = t % ht;
    v = (t / ht) % vt;
    f = t / (ht * vt);
    b.h  = 11'(h);
    b.v  = 11'(v);
    b.hb = (h >= ha);
    b.hs = (h >= hss) && (h < hsp);
    b.vb = (v >= va);
    b.vs = (v >= vss) && (v < vsp);
    b.fs = a && (t > 0) && ((t % (ht * vt)) == 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
    b.fc = 16'((base + f) % 65536);
`else
    b.fc = 16'd0;
    if (base < 0 || f < 0) b.fc = 16'hdead;
`endif
    return b;
  endfunction

  function automatic bus_t exp_b();
    return model(ticks, adv, 1344, 1024, 1048, 1184, 806, 768, 771, 777, 0);
  endfunction

  function automatic bus_t exp_s();
    return model(ticks, adv, 20, 12, 14, 17, 15, 10, 11, 13, fc_base_s);
  endfunction

  function automatic bus_t act_b();
    return '{hcount_b, vcount_b, hsync_b, vsync_b, hblnk_b, vblnk_b, fs_b, fc_b};
  endfunction

  function automatic bus_t act_s();
    return '{{6'd0, hcount_s}, {6'd0, vcount_s}, hsync_s, vsync_s, hblnk_s, vblnk_s, fs_s, fc_s};
  endfunction

  // One clock edge with the given enable; the model advances in lock-step, sampling is 1 ns after the edge.
  task automatic applyStimulus(input bit e);
    en = e;
    @(posedge clk);
    if (e) ticks++;
    adv = e;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en    = 1'b1;
    ticks = 0; adv = 1'b0; fc_base_s = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (act_b() !== exp_b()) begin
      errors++; $display("[TB] FAIL reset_big act=%h exp=%h", act_b(), exp_b());
    end
    checks++;
    if (act_s() !== exp_s()) begin
      errors++; $display("[TB] FAIL reset_small act=%h exp=%h", act_s(), exp_s());
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b1);
      checks++;
      if (hcount_b !== 11'(i) || vcount_b !== 11'd0 || {hsync_b, vsync_b, hblnk_b, vblnk_b, fs_b} !== 5'b0) begin
        errors++; $display("[TB] FAIL post_reset_count act=h%0d v%0d flags=%b exp=h%0d v0 flags=00000",
                           hcount_b, vcount_b, {hsync_b, vsync_b, hblnk_b, vblnk_b, fs_b}, i);
      end
    end
  endtask

  task automatic test_line();
    int hs_cnt = 0;
    while (ticks < 1346) begin
      applyStimulus(1'b1);
      if (hsync_b === 1'b1) hs_cnt++;
      checks++;
      if (act_b() !== exp_b()) begin
        errors++; $display("[TB] FAIL line_big t=%0d act=%h exp=%h", ticks, act_b(), exp_b());
      end
      if (ticks == 1344) begin
        checks++;
        if (hcount_b !== 11'd0 || vcount_b !== 11'd1 || hblnk_b !== 1'b0) begin
          errors++; $display("[TB] FAIL line_wrap act=h%0d v%0d hb%b exp=h0 v1 hb0", hcount_b, vcount_b, hblnk_b);
        end
      end
    end
    checks++;
    if (hs_cnt != 136) begin
      errors++; $display("[TB] FAIL hsync_width act=%0d exp=136", hs_cnt);
    end
  endtask

  task automatic test_frame();
    int fs_cnt = 0, vs_cnt = 0, vb_cnt = 0;
    for (int i = 0; i < 600; i++) begin
      applyStimulus(1'b1);
      fs_cnt += int'(fs_s === 1'b1);
      vs_cnt += int'(vsync_s === 1'b1);
      vb_cnt += int'(vblnk_s === 1'b1);
      checks++;
      if (act_s() !== exp_s()) begin
        errors++; $display("[TB] FAIL frame_small t=%0d act=%h exp=%h", ticks, act_s(), exp_s());
      end
    end
    checks++;
    if (fs_cnt != 2 || vs_cnt != 80 || vb_cnt != 200) begin
      errors++; $display("[TB] FAIL frame_counts act=fs%0d vs%0d vb%0d exp=fs2 vs80 vb200", fs_cnt, vs_cnt, vb_cnt);
    end
  endtask

  task automatic test_en_hold();
    int guard = 0;
    while ((ticks % 1344) != 1100 && guard < 2000) begin
      applyStimulus(1'b1);
      guard++;
    end
    checks++;
    if (hcount_b !== 11'd1100 || hsync_b !== 1'b1) begin
      errors++; $display("[TB] FAIL hold_reach act=h%0d hs%b exp=h1100 hs1", hcount_b, hsync_b);
    end
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0);
      checks++;
      if (act_b() !== exp_b() || hcount_b !== 11'd1100) begin
        errors++; $display("[TB] FAIL hold_frozen act=%h exp=%h", act_b(), exp_b());
      end
    end
    applyStimulus(1'b1);
    checks++;
    if (hcount_b !== 11'd1101 || act_b() !== exp_b()) begin
      errors++; $display("[TB] FAIL hold_resume act=h%0d exp=h1101", hcount_b);
    end
  endtask

  task automatic test_en_at_wrap();
    int guard = 0;
    while ((ticks % 300) != 299 && guard < 400) begin
      applyStimulus(($urandom_range(0, 3) != 0));
      guard++;
    end
    applyStimulus(1'b1);
    checks++;
    if (fs_s !== 1'b1 || act_s() !== exp_s()) begin
      errors++; $display("[TB] FAIL wrap_pulse act=%h exp=%h", act_s(), exp_s());
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0);
      checks++;
      if (fs_s !== 1'b0 || act_s() !== exp_s()) begin
        errors++; $display("[TB] FAIL wrap_no_stretch act=%h exp=%h", act_s(), exp_s());
      end
    end
  endtask

  task automatic test_random_enable();
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 3) != 0));
      checks++;
      if (act_s() !== exp_s()) begin
        errors++; $display("[TB] FAIL rand_small t=%0d act=%h exp=%h", ticks, act_s(), exp_s());
      end
      checks++;
      if (act_b() !== exp_b()) begin
        errors++; $display("[TB] FAIL rand_big t=%0d act=%h exp=%h", ticks, act_b(), exp_b());
      end
    end
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    while ((ticks % 300) != 150 && guard < 400) begin
      applyStimulus(1'b1);
      guard++;
    end
    checks++;
    if (hcount_s !== 5'd10 || vcount_s !== 5'd7) begin
      errors++; $display("[TB] FAIL mid_reach act=h%0d v%0d exp=h10 v7", hcount_s, vcount_s);
    end
    #2;
    rst_n = 1'b0;
    ticks = 0; adv = 1'b0; fc_base_s = 0;
    #1;
    checks++;
    if (act_s() !== exp_s()) begin
      errors++; $display("[TB] FAIL mid_async_small act=%h exp=%h", act_s(), exp_s());
    end
    checks++;
    if (act_b() !== exp_b()) begin
      errors++; $display("[TB] FAIL mid_async_big act=%h exp=%h", act_b(), exp_b());
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 25; i++) begin
      applyStimulus(1'b1);
      checks++;
      if (act_s() !== exp_s() || act_b() !== exp_b()) begin
        errors++; $display("[TB] FAIL mid_restart t=%0d act=%h exp=%h", ticks, act_s(), exp_s());
      end
    end
  endtask

  task automatic test_frame_cnt();
    int guard = 0;
`ifdef VGA_TIMING_FRAME_CNT_EN
    force dut_s.frame_cnt_q = 16'hffff;
    #1;
    release dut_s.frame_cnt_q;
    fc_base_s = 65535 - (ticks / 300);
`endif
    while ((ticks % 300) != 0 && guard < 400) begin
      applyStimulus(1'b1);
      guard++;
    end
    checks++;
    if (fs_s !== 1'b1 || fc_s !== 16'd0 || act_s() !== exp_s()) begin
      errors++; $display("[TB] FAIL frame_cnt_wrap act=fs%b fc%0d exp=fs1 fc0", fs_s, fc_s);
    end
    checks++;
    if (fc_b !== 16'd0) begin
      errors++; $display("[TB] FAIL frame_cnt_big act=%0d exp=0", fc_b);
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_en_hold();
    test_en_at_wrap();
    test_random_enable();
    test_reset_mid();
    test_frame_cnt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
